ci_issue_master: RTL
====================

// Module: ci_issue_master
// PURPOSE
//  Initiator side of the Nios II custom-instruction (CI) handshake used by our CORDIC accumulate blocks.
//  Buffers float32 samples written by a host, streams them to a pipelined CI slave one per cycle
//  (datab=1 marks the first sample = accumulator clear), counts done pulses, returns final accumulated result.
//  Sits between a CPU/DMA write port and any CI slave with ports clk_en/reset/start/dataa/datab/result/done.
// PARAMETERS
//  DEPTH     16   sample FIFO entries; power of 2, >=2
//  AW        4    log2(DEPTH)
//  TIMEOUT   64   cycles without ci_done before error (used only with CI_TIMEOUT_EN)
// PORTS
//  clock       in   1      system clock, all logic on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  wr_en       in   1      push wr_data into sample FIFO (ignored when full or busy)
//  wr_data     in   32     float32 sample
//  full        out  1      FIFO full
//  level       out  AW+1   FIFO occupancy 0..DEPTH
//  go          in   1      start a batch (ignored when busy or level==0)
//  busy        out  1      batch in progress
//  res_valid   out  1      one-cycle pulse: res_data holds batch result
//  res_data    out  32     ci_result captured at final done; holds until next res_valid
//  err         out  1      sticky timeout flag; cleared by next accepted go (constant 0 without macro)
//  ci_clk_en   out  1      CI clock enable
//  ci_reset    out  1      CI slave synchronous reset, active-high
//  ci_start    out  1      CI issue strobe
//  ci_dataa    out  32     sample operand
//  ci_datab    out  32     32'd1 on first sample of batch, 32'd0 otherwise
//  ci_result   in   32     slave result
//  ci_done     in   1      one pulse per accepted start, in issue order
// BEHAVIOUR
//  Reset (async): FSM=IDLE, FIFO empty, level=0, full=0, busy=0, res_valid=0, res_data=0, err=0,
//   ci_clk_en=0, ci_reset=1, ci_start=0, ci_dataa=0, ci_datab=0; counters issued/completed=0.
//  FSM states: IDLE, CLEAR, ISSUE, DRAIN, FINISH.
//   IDLE: ci_reset=0, ci_clk_en=0. go && level!=0 -> CLEAR, latch batch=level, busy=1, err=0.
//   CLEAR: one cycle, ci_clk_en=1, ci_reset=1 (flushes slave pipeline) -> ISSUE.
//   ISSUE: each cycle pop FIFO head; registered ci_start=1, ci_dataa=head, ci_datab=(issued==0);
//    issued++. After pop making issued==batch -> DRAIN (ci_start=0 next cycle). Back-to-back, no gaps.
//   DRAIN: ci_clk_en=1, ci_start=0, ci_dataa/ci_datab=0. Wait completed==batch -> FINISH.
//   FINISH: res_data<=ci_result captured on the cycle of final ci_done; res_valid=1 for exactly one
//    cycle; busy=0; -> IDLE.
//  ci_done counted in every non-IDLE state, including ISSUE (slave latency may be < batch).
//   Done on same cycle as last issue is counted; completed never exceeds issued (extra dones ignored).
//  Latency go -> res_valid = 2 + batch + slave latency cycles.
//  FIFO: wr_en accepted only in IDLE and !full; push when full is dropped, level unchanged.
//   Pointers AW bits, wrap at DEPTH; level=DEPTH <=> full. Pushes during busy dropped.
//  go while busy ignored; go and wr_en same cycle in IDLE: write accepted, batch=level before the write.
//  reset_n asserted mid-batch: everything returns to reset values immediately; FIFO contents lost.
// CONFIGURATION
//  CI_TIMEOUT_EN defined: watchdog counts cycles in ISSUE/DRAIN since last ci_done (or since CLEAR);
//   reaching TIMEOUT -> err=1, FIFO flushed, ci_reset pulsed 1 cycle, FSM -> IDLE, busy=0,
//   no res_valid, res_data unchanged.
//  CI_TIMEOUT_EN undefined: no watchdog, DRAIN waits forever, err tied 0.
// TESTING
//  T1 reset: reset_n=0 mid-clock -> all outputs at reset values before next edge; ci_reset=1.
//  T2 batch of 4: push 41c80000,00000000,42480000,42960000; go -> 4 consecutive ci_start, datab 1,0,0,0,
//   dataa in push order; slave model latency 17 returns 45a219d4 on 4th done -> res_valid pulse, res_data=45a219d4.
//  T3 FIFO full: 17 pushes with DEPTH=16 -> full=1 after 16th, level=16, 17th dropped; batch issues 16.
//  T4 go ignored: go with level=0 -> busy stays 0; go during busy -> no effect; wr_en while busy -> level unchanged.
//  T5 latency-1 slave: done arrives during ISSUE -> completed counted, res_valid 1 cycle after last done.
//  T6 CI_TIMEOUT_EN, TIMEOUT=64: slave never asserts done -> err=1 on 64th DRAIN/ISSUE cycle, busy=0,
//   res_valid never pulses; next go clears err.

Source files
------------

// File: rtl/ci_issue_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ci_issue_master_if
// Purpose  : Host write/result port plus Nios II custom-instruction initiator
//            port bundle used by ci_issue_master.
// Revision : 1.0
// ============================================================================
interface ci_issue_master_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          full;
    logic [AW:0]   level;
    logic          go;
    logic          busy;
    logic          res_valid;
    logic [31:0]   res_data;
    logic          err;
    logic          ci_clk_en;
    logic          ci_reset;
    logic          ci_start;
    logic [31:0]   ci_dataa;
    logic [31:0]   ci_datab;
    logic [31:0]   ci_result;
    logic          ci_done;

    modport master (
        input  wr_en, wr_data, go, ci_result, ci_done,
        output full, level, busy, res_valid, res_data, err,
        output ci_clk_en, ci_reset, ci_start, ci_dataa, ci_datab
    );

    modport slave (
        output wr_en, wr_data, go, ci_result, ci_done,
        input  full, level, busy, res_valid, res_data, err,
        input  ci_clk_en, ci_reset, ci_start, ci_dataa, ci_datab
    );
endinterface
`default_nettype wire

// File: rtl/ci_issue_master.sv
`default_nettype none
// ============================================================================
// Module   : ci_issue_master
// Purpose  : Buffers host samples and streams them back-to-back to a pipelined
//            CI slave, returning the result captured on the final done.
//            Optional watchdog enabled by defining CI_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ci_issue_master #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    ci_issue_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count, r_batch, r_issued, r_completed;
    logic [AW:0]   w_batch_nxt, w_issued_nxt, w_completed_nxt, w_completed_cnt;
    logic          r_busy, r_res_valid, r_err, r_clk_en, r_ci_reset, r_start;
    logic [31:0]   r_res_data, r_dataa, r_datab;
    logic          w_busy_nxt, w_res_valid_nxt, w_err_nxt, w_clk_en_nxt, w_ci_reset_nxt, w_start_nxt;
    logic [31:0]   w_res_data_nxt, w_dataa_nxt, w_datab_nxt;
    logic          w_push, w_pop, w_flush, w_done_ok, w_full, w_last_done;

`ifdef CI_TIMEOUT_EN
    localparam int                WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   C_TIMEOUT = WD_W'(TIMEOUT);
    logic [WD_W-1:0]              r_wd, w_wd_nxt;
`endif

    assign w_full          = (r_count == C_DEPTH);
    // Dones beyond the number of issued starts are ignored, so completed never overtakes issued.
    assign w_done_ok       = (r_state != S_IDLE) && bus.ci_done && (r_completed < r_issued);
    assign w_completed_cnt = r_completed + {{AW{1'b0}}, w_done_ok};
    assign w_last_done     = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) && (w_completed_cnt == r_batch);

    always_comb begin
        w_state_nxt     = r_state;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_flush         = 1'b0;
        w_batch_nxt     = r_batch;
        w_issued_nxt    = r_issued;
        w_completed_nxt = w_completed_cnt;
        w_busy_nxt      = r_busy;
        w_res_valid_nxt = 1'b0;
        w_res_data_nxt  = r_res_data;
        w_err_nxt       = r_err;
        w_clk_en_nxt    = 1'b0;
        w_ci_reset_nxt  = 1'b0;
        w_start_nxt     = 1'b0;
        w_dataa_nxt     = 32'd0;
        w_datab_nxt     = 32'd0;
        case (r_state)
            S_IDLE: begin
                w_push = bus.wr_en && !w_full;
                // Batch size is the occupancy before a same-cycle write lands.
                if (bus.go && (r_count != '0)) begin
                    w_state_nxt     = S_CLEAR;
                    w_batch_nxt     = r_count;
                    w_issued_nxt    = '0;
                    w_completed_nxt = '0;
                    w_busy_nxt      = 1'b1;
                    w_err_nxt       = 1'b0;
                    w_clk_en_nxt    = 1'b1;
                    w_ci_reset_nxt  = 1'b1;
                end
            end
            S_CLEAR: begin
                w_state_nxt  = S_ISSUE;
                w_clk_en_nxt = 1'b1;
                w_pop        = 1'b1;
                w_start_nxt  = 1'b1;
                w_dataa_nxt  = r_mem[r_rptr];
                w_datab_nxt  = 32'd1;
                w_issued_nxt = r_issued + C_ONE;
            end
            S_ISSUE: begin
                w_clk_en_nxt = 1'b1;
                if (r_issued == r_batch) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_pop        = 1'b1;
                    w_start_nxt  = 1'b1;
                    w_dataa_nxt  = r_mem[r_rptr];
                    w_issued_nxt = r_issued + C_ONE;
                end
            end
            S_DRAIN: begin
                w_clk_en_nxt = 1'b1;
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_last_done) begin
            w_state_nxt     = S_FINISH;
            w_clk_en_nxt    = 1'b0;
            w_res_valid_nxt = 1'b1;
            w_res_data_nxt  = bus.ci_result;
            w_busy_nxt      = 1'b0;
        end

`ifdef CI_TIMEOUT_EN
        w_wd_nxt = '0;
        if ((r_state == S_ISSUE) || (r_state == S_DRAIN)) begin
            w_wd_nxt = w_done_ok ? '0 : (r_wd + WD_W'(1));
            // Abort: drop the batch, flush the FIFO and pulse the slave reset for one cycle.
            if (!w_last_done && (w_wd_nxt == C_TIMEOUT)) begin
                w_state_nxt    = S_IDLE;
                w_err_nxt      = 1'b1;
                w_busy_nxt     = 1'b0;
                w_flush        = 1'b1;
                w_pop          = 1'b0;
                w_ci_reset_nxt = 1'b1;
                w_start_nxt    = 1'b0;
                w_dataa_nxt    = 32'd0;
                w_datab_nxt    = 32'd0;
                w_issued_nxt   = r_issued;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_batch     <= '0;
            r_issued    <= '0;
            r_completed <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_err       <= 1'b0;
            r_clk_en    <= 1'b0;
            r_ci_reset  <= 1'b1;
            r_start     <= 1'b0;
            r_dataa     <= 32'd0;
            r_datab     <= 32'd0;
        end else begin
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
                if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
                if (w_push && !w_pop)      r_count <= r_count + C_ONE;
                else if (w_pop && !w_push) r_count <= r_count - C_ONE;
            end
            r_batch     <= w_batch_nxt;
            r_issued    <= w_issued_nxt;
            r_completed <= w_completed_nxt;
            r_busy      <= w_busy_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_err       <= w_err_nxt;
            r_clk_en    <= w_clk_en_nxt;
            r_ci_reset  <= w_ci_reset_nxt;
            r_start     <= w_start_nxt;
            r_dataa     <= w_dataa_nxt;
            r_datab     <= w_datab_nxt;
        end
    end

`ifdef CI_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_wd <= '0;
        else          r_wd <= w_wd_nxt;
    end
`endif

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= bus.wr_data;
    end

    assign bus.full      = w_full;
    assign bus.level     = r_count;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.err       = r_err;
    assign bus.ci_clk_en = r_clk_en;
    assign bus.ci_reset  = r_ci_reset;
    assign bus.ci_start  = r_start;
    assign bus.ci_dataa  = r_dataa;
    assign bus.ci_datab  = r_datab;
endmodule
`default_nettype wire
